// File: rtl/core_receiver.sv
// core_receiver: 8N1 UART receive engine. Oversamples the serial line at clk,
// recovers frames (start, WORD_WIDTH data bits LSB first, one stop bit) and
// pushes each good word into a FIFO-style sink through a one-cycle write strobe.
// Framing errors and overruns (word dropped while the sink is full) are
// reported as one-cycle pulses.
module core_receiver #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int WORD_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  input  logic                  full,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  we,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  // Clocks per bit and the start-bit mid-point offset. DIV must be >= 4.
  localparam int DIV  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(WORD_WIDTH + 1);

  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] IDX_LAST      = BW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [WORD_WIDTH-1:0] shreg;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous RX line; resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments model the flop chain; blocking here
      // would collapse both stages into one.
      sync_q <= {sync_q[0], din};
    end
  end

  // Receive FSM: start-bit validation, mid-bit data sampling, stop-bit decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      dout      <= '0;
      we        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle, so each assertion below
      // lasts exactly one clock.
      we        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == CNT_HALF_LAST) begin
            if (rx_s) begin
              // Line back high at mid start bit: treat as a glitch.
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_BIT_LAST) begin
            shreg   <= {rx_s, shreg[WORD_WIDTH-1:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              // Return to IDLE at mid stop bit so an immediate next start
              // bit is still caught.
              state <= S_IDLE;
              if (!full) begin
                dout <= shreg;
                we   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // A held-low line yields a single frame_err; wait for idle level.
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_receiver.sv
// tb_core_receiver: self-checking bench for core_receiver. Frames are driven
// bit-serially on din; each frame's expected outcome (write, overrun or framing
// error) and its start cycle are queued, and a monitor matches every DUT pulse
// against that queue, checking kind, word, dout persistence and latency.
module tb_core_receiver;

  localparam int CF      = 1_000_000;
  localparam int BR      = 100_000;
  localparam int DIV     = CF / BR;
  localparam int HALF    = DIV / 2;
  localparam int LATENCY = 3 + HALF + 9 * DIV;

  typedef enum int {EV_WE = 0, EV_OVR = 1, EV_FE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         t0;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       full;
  logic [7:0] dout;
  logic       we;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  ev_t        exp_q[$];
  logic [7:0] exp_dout = 8'h00;
  int         bad_excl = 0;
  int         bad_consec = 0;
  int         bad_hold = 0;

  core_receiver #(
    .CLOCK_FREQUENCY(CF),
    .BAUD_RATE      (BR),
    .WORD_WIDTH     (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .full     (full),
    .dout     (dout),
    .we       (we),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one 8N1 frame starting at the current negedge; queue its expected outcome.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic f, input int hold_low);
    ev_t e;
    full   = f;
    e.kind = !stop_bit ? EV_FE : (f ? EV_OVR : EV_WE);
    e.data = d;
    e.t0   = cyc;
    exp_q.push_back(e);
    din = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = d[i];
      repeat (DIV) @(negedge clk);
    end
    din = stop_bit;
    repeat (DIV) @(negedge clk);
    if (hold_low > 0) begin
      din = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    din = 1'b1;
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: match pulses to expected events and track protocol violations.
  initial begin
    logic [2:0] prev_p = 3'b000;
    logic [7:0] prev_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [2:0] p;
        p = {we, overrun, frame_err};
        if ((32'(we) + 32'(overrun) + 32'(frame_err)) > 1) bad_excl++;
        if ((p & prev_p) != 3'b000) bad_consec++;
        if (dout != prev_dout && !we) bad_hold++;
        if (p != 3'b000) begin
          if (exp_q.size() == 0) begin
            check("spurious_pulse", 32'(p), 32'd0);
          end else begin
            ev_t e;
            int  lat;
            int  got_kind;
            e = exp_q.pop_front();
            got_kind = we ? EV_WE : (overrun ? EV_OVR : EV_FE);
            check("pulse_kind", 32'(got_kind), 32'(e.kind));
            if (e.kind == EV_WE) exp_dout = e.data;
            check("dout", 32'(dout), 32'(exp_dout));
            lat = cyc - e.t0;
            check("latency", (lat >= LATENCY - 1 && lat <= LATENCY + 1) ? 32'(LATENCY) : 32'(lat),
                  32'(LATENCY));
          end
        end
        prev_p = p;
      end else begin
        prev_p = 3'b000;
      end
      prev_dout = dout;
    end
  end

  initial begin
    logic [7:0] d;
    int         r;
    int         gap;
    bit         drained;

    rst_n = 1'b0;
    din   = 1'b1;
    full  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Two isolated frames.
    send_frame(8'h55, 1'b1, 1'b0, 0);
    idle(30);
    send_frame(8'hA3, 1'b1, 1'b0, 0);
    idle(20);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    idle(20);
    check("b2b_dout", 32'(dout), 32'h81);

    // Short glitch: no pulse, busy back low within HALF+3 cycles of release.
    din = 1'b0;
    repeat (3) @(negedge clk);
    din = 1'b1;
    repeat (HALF + 3) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'h0);
    idle(20);

    // Framing error with a 50-cycle break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, 50);
    idle(30);
    check("break_busy", 32'(busy), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    idle(20);
    check("after_fe_dout", 32'(dout), 32'h3C);

    // Overrun: word dropped while full, dout keeps the previous word.
    send_frame(8'h12, 1'b1, 1'b0, 0);
    idle(10);
    send_frame(8'h34, 1'b1, 1'b1, 0);
    full = 1'b0;
    idle(10);
    check("overrun_hold", 32'(dout), 32'h12);
    send_frame(8'h56, 1'b1, 1'b0, 0);
    idle(20);

    // Reset during data bit 4 of 0x99: asynchronous return to reset values.
    d   = 8'h99;
    din = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = d[i];
      repeat (DIV) @(negedge clk);
    end
    din = d[4];
    repeat (HALF) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst_n    = 1'b0;
    exp_dout = 8'h00;
    #1;
    check("mid_rst_dout", 32'(dout), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_we", 32'(we), 32'h0);
    check("mid_rst_pulses", 32'({frame_err, overrun}), 32'h0);
    din = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    idle(20);
    check("after_rst_dout", 32'(dout), 32'hC3);

    // Randomized frames: random data, occasional bad stop bit or full sink,
    // random full level during idle gaps (must be ignored).
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom);
      r   = $urandom_range(0, 7);
      gap = (r == 0) ? $urandom_range(5, 15) : $urandom_range(0, 15);
      send_frame(d, (r != 0), (r == 1 || r == 2), 0);
      full = 1'($urandom);
      if (gap > 0) idle(gap);
    end
    full = 1'b0;

    // Bounded drain of outstanding expectations.
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) drained = 1'b1;
    end
    check("pending_events", 32'(exp_q.size()), 32'd0);
    check("exclusive_violations", 32'(bad_excl), 32'd0);
    check("consecutive_pulses", 32'(bad_consec), 32'd0);
    check("dout_changed_without_we", 32'(bad_hold), 32'd0);
    check("final_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_receiver.md
# core_receiver

UART receive engine, the inbound counterpart of `core_transmitter` on the same PL-side serial link. It oversamples the asynchronous serial input at the system clock and recovers 8N1 frames (start, `WORD_WIDTH` data bits LSB first, one stop bit). Each good word is pushed into a downstream FIFO-style sink through a one-cycle write strobe, gated by the sink's `full` flag. Framing errors and overruns are flagged with one-cycle pulses.

## Interface
- `CLOCK_FREQUENCY`, default 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `WORD_WIDTH`, default 8: data bits per frame.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial RX line, asynchronous to clk, idles high.
- `full`  in  1  sink cannot accept a word this cycle.
- `dout`  out  WORD_WIDTH  last received word.
- `we`  out  1  write strobe, one cycle per accepted word.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good word dropped because `full`=1.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Divisor: DIV = CLOCK_FREQUENCY / BAUD_RATE (integer, truncated); HALF = DIV / 2. Counter width is $clog2(DIV). DIV ≥ 4 is required.
- `din` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized value `rx_s`.
- IDLE: when `rx_s`=0, go to START and clear the counter.
- START: count 0..HALF-1. At HALF-1, sample `rx_s`.
  - Sample 1 means a glitch: return to IDLE. No pulse.
  - Sample 0: go to DATA, clear the counter and the bit index.
- DATA: count 0..DIV-1. At DIV-1:
  - Shift `rx_s` into the MSB of the shift register (right-shift, so the first bit ends in bit 0).
  - Increment the bit index and clear the counter.
  - After WORD_WIDTH bits, go to STOP.
- STOP: count 0..DIV-1. At DIV-1, sample `rx_s`.
  - Sample 1 and `full`=0: load `dout` with the shift register, pulse `we`, go to IDLE.
  - Sample 1 and `full`=1: pulse `overrun`, leave `dout` unchanged, go to IDLE. The word is lost.
  - Sample 0: pulse `frame_err`, no `we`, go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. A line held low (break) yields exactly one `frame_err` and no further frames.
- `full` is sampled only at the stop-bit decision cycle. Its value at any other time is ignored.
- `we`, `overrun` and `frame_err` are mutually exclusive and never high for more than one consecutive cycle.

## Timing
- Reset values: `dout`=0, `we`=0, `frame_err`=0, `overrun`=0, `busy`=0. State resets to IDLE, counters to 0, synchronizer flops to 1.
- Reset asserted mid-frame aborts immediately with no pulse. After release, the receiver needs `rx_s`=1 before a stray low level can start a frame. A frame already in progress on the line may be mis-framed; this is accepted, and the block recovers by the next idle gap.
- All outputs are registered.
- `dout` changes only in the cycle `we` rises, and holds until the next `we`.
- Latency: the synchronizer adds 2 cycles; the IDLE→START transition adds 1. The `we`/`overrun`/`frame_err` pulse appears 3 + HALF + (WORD_WIDTH+1)·DIV cycles (±1) after `din` falls.
- Back-to-back frames: returning to IDLE at mid-stop-bit leaves about DIV/2 cycles of margin. A start bit that immediately follows a stop bit must be received with no loss.
- `busy` rises the cycle after IDLE→START and falls the cycle after returning to IDLE.

## Test plan
Use `CLOCK_FREQUENCY`=1_000_000 and `BAUD_RATE`=100_000 (DIV=10, HALF=5), and `full`=0 unless stated.
- Single frames 0x55, then 0xA3 after 30 idle cycles -> two `we` pulses with `dout`=0x55 then 0xA3, each 98±1 cycles after its falling edge. No `frame_err` or `overrun`.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> exactly three `we` pulses in order with the correct `dout`. `busy` drops only briefly between frames.
- Glitch: `din` low for 3 cycles, then high -> no pulses. `busy` returns to 0 within HALF+3 cycles.
- Framing error: send 0x3C with stop bit 0, then hold `din` low 50 cycles, then idle, then send 0x3C normally -> one `frame_err` and no `we` for the first frame. Then one `we` with `dout`=0x3C.
- Overrun: receive 0x12 normally, then hold `full`=1 while sending 0x34 -> `overrun` pulses once, no `we`, `dout` stays 0x12. Release `full` and send 0x56 -> `we` with `dout`=0x56.
- Reset mid-frame: assert `rst_n`=0 during data bit 4 of 0x99 -> all outputs return to reset values asynchronously. After release and 20 idle cycles, frame 0xC3 gives `we` with `dout`=0xC3.
